// File: rtl/ts_out_if.sv
// ts_out_if: pulls a de-interleaved frame from the byte memory on ts_int and emits it as a packetised
// valid/ready byte stream. Define TS_SYNC_CHECK_EN to add the 0x47 sync-byte checker (sync_err, sync_err_cnt).
`timescale 1ns/1ps
module ts_out_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_LEN    = 188,
  parameter int LEN_W      = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ts_int,
  input  logic [LEN_W-1:0] frame_bytes,
  output logic             ts_en_rd,
  input  logic             ts_en_out,
  input  logic [7:0]       ts_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             busy,
  output logic             frame_done,
`ifdef TS_SYNC_CHECK_EN
  output logic             ovf_err,
  output logic             sync_err,
  output logic [15:0]      sync_err_cnt,
  output logic [1:0]       dbg_state
`else
  output logic             ovf_err,
  output logic [1:0]       dbg_state
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_n;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_count, outstanding;
  logic [LEN_W-1:0] rd_left, out_left, pend_len, start_len;
  logic [PW-1:0]    pkt_cnt;
  logic [CW:0]      credit;
  logic             pending, start, ts_valid, ret_ok, fifo_full, fifo_wr, accept, issue, last_accept;

  // Handshakes: an output byte transfers on a rising edge with out_valid && out_ready, and
  // out_data/out_sop/out_eop hold while stalled. Each cycle ts_en_rd is high is one request; the
  // memory answers every request with exactly one ts_en_out strobe, in order, after any latency.
  assign ts_valid    = ts_int && (frame_bytes != '0);
  assign ret_ok      = ts_en_out && (outstanding != '0);
  assign fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_wr     = ret_ok && !fifo_full;
  assign out_valid   = (fifo_count != '0);
  assign accept      = out_valid && out_ready;
  assign last_accept = accept && (state != IDLE) && (out_left == LEN_W'(1));
  // In-flight requests already hold a FIFO slot, so the FIFO can never be asked to overflow.
  assign credit      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign issue       = (state == READ) && (rd_left != '0) && (credit < (CW+1)'(FIFO_DEPTH));
  assign out_data    = out_valid ? mem[rd_ptr] : 8'h00;
  assign out_sop     = out_valid && (pkt_cnt == '0);
  assign out_eop     = out_valid && ((pkt_cnt == PW'(PKT_LEN - 1)) || (out_left == LEN_W'(1)));
  assign busy        = (state != IDLE);
  assign dbg_state   = state;

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    start_len = frame_bytes;
    case (state)
      IDLE:    if (ts_valid) start = 1'b1;
      READ:    if (rd_left == '0) state_n = DRAIN;
      default: ;
    endcase
    // A queued frame starts in the same edge the current one finishes.
    if (last_accept) begin
      state_n = IDLE;
      if (pending) begin
        start     = 1'b1;
        start_len = pend_len;
      end else if (ts_valid) begin
        start = 1'b1;
      end
    end
    if (start) state_n = READ;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ts_en_rd    <= 1'b0;
      frame_done  <= 1'b0;
      ovf_err     <= 1'b0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_left     <= '0;
      out_left    <= '0;
      pkt_cnt     <= '0;
      pending     <= 1'b0;
      pend_len    <= '0;
    end else begin
      state       <= state_n;
      ts_en_rd    <= issue;
      frame_done  <= last_accept;
      outstanding <= outstanding + CW'(issue) - CW'(ret_ok);
      fifo_count  <= fifo_count + CW'(fifo_wr) - CW'(accept);
      if (ret_ok && fifo_full) ovf_err <= 1'b1;
      if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
      if (accept) rd_ptr <= rd_ptr + AW'(1);
      if (start) begin
        rd_left  <= start_len;
        out_left <= start_len;
        pkt_cnt  <= '0;
      end else begin
        if (issue) rd_left <= rd_left - LEN_W'(1);
        if (accept && (out_left != '0)) out_left <= out_left - LEN_W'(1);
        if (accept) pkt_cnt <= out_eop ? '0 : pkt_cnt + PW'(1);
      end
      if (start && pending) begin
        pending <= ts_valid;
        if (ts_valid) pend_len <= frame_bytes;
      end else if (ts_valid && busy && !start) begin
        pending  <= 1'b1;
        pend_len <= frame_bytes;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= ts_dout;
  end

`ifdef TS_SYNC_CHECK_EN
  logic sync_bad;
  assign sync_bad = accept && out_sop && (out_data != 8'h47);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_err     <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      sync_err <= sync_bad;
      if (sync_bad && (sync_err_cnt != 16'hFFFF)) sync_err_cnt <= sync_err_cnt + 16'd1;
    end
  end
`endif
endmodule
